// File: rtl/pipeir_queue.sv
// IF/ID pipeline register fronted by a DEPTH-entry instruction FIFO, so decode
// stalls back-pressure fetch only once the queue is full.
module pipeir_queue #(
    parameter int              PC_W  = 32,
    parameter int              INS_W = 32,
    parameter int              DEPTH = 4,
    parameter logic [INS_W-1:0] NOP  = '0
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   f_valid,
    input  logic [PC_W-1:0]        f_pc4,
    input  logic [INS_W-1:0]       f_ins,
    output logic                   f_ready,
    input  logic                   wpcir,
    input  logic                   flush,
    output logic [PC_W-1:0]        dpc4,
    output logic [INS_W-1:0]       inst,
    output logic                   d_valid,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [PC_W-1:0]  r_mem_pc  [DEPTH];
    logic [INS_W-1:0] r_mem_ins [DEPTH];
    logic [AW-1:0]    r_rd;
    logic [AW-1:0]    r_wr;
    logic [CW-1:0]    r_count;
    logic [PC_W-1:0]  r_dpc4;
    logic [INS_W-1:0] r_inst;
    logic             r_dvalid;

    logic w_empty;
    logic w_ready;
    logic w_accept;
    logic w_pop;
    logic w_push;

    // f_ready is a pure function of occupancy so fetch sees no combinational path.
    assign w_empty  = (r_count == '0);
    assign w_ready  = (r_count < CW'(DEPTH));
    assign w_accept = f_valid && w_ready && !flush;
    assign w_pop    = !flush && wpcir && !w_empty;
    // An empty queue with decode advancing bypasses straight to the output register.
    assign w_push   = w_accept && !(wpcir && w_empty);

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem_pc[r_wr]  <= f_pc4;
            r_mem_ins[r_wr] <= f_ins;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_dpc4   <= '0;
            r_inst   <= NOP;
            r_dvalid <= 1'b0;
            r_rd     <= '0;
            r_wr     <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_dpc4   <= '0;
            r_inst   <= NOP;
            r_dvalid <= 1'b0;
            r_rd     <= '0;
            r_wr     <= '0;
            r_count  <= '0;
        end else begin
            if (wpcir) begin
                if (!w_empty) begin
                    r_dpc4   <= r_mem_pc[r_rd];
                    r_inst   <= r_mem_ins[r_rd];
                    r_dvalid <= 1'b1;
                end else if (w_accept) begin
                    r_dpc4   <= f_pc4;
                    r_inst   <= f_ins;
                    r_dvalid <= 1'b1;
                end else begin
                    r_dpc4   <= '0;
                    r_inst   <= NOP;
                    r_dvalid <= 1'b0;
                end
            end
            if (w_pop)  r_rd <= r_rd + AW'(1);
            if (w_push) r_wr <= r_wr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign f_ready = w_ready;
    assign dpc4    = r_dpc4;
    assign inst    = r_inst;
    assign d_valid = r_dvalid;
    assign count   = r_count;
endmodule
